// File: rtl/rambus_block_mover.sv
// Wishbone classic block mover for the OpenRAM rambus port B.
// Optional ack-wait statistic enabled by RAMBUS_MOVER_STATS_EN.
module rambus_block_mover #(
    parameter int ADDR_WIDTH = 10,
    parameter int TIMEOUT    = 255,
    parameter int STAT_WIDTH = 16
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_n_i,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic [31:0]           wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [31:0]           rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [STAT_WIDTH-1:0] stat_wait,
    output logic                  rambus_wb_clk_o,
    output logic                  rambus_wb_rst_o,
    output logic                  rambus_wb_stb_o,
    output logic                  rambus_wb_cyc_o,
    output logic                  rambus_wb_we_o,
    output logic [3:0]            rambus_wb_sel_o,
    output logic [31:0]           rambus_wb_dat_o,
    output logic [ADDR_WIDTH-1:0] rambus_wb_adr_o,
    input  logic                  rambus_wb_ack_i,
    input  logic [31:0]           rambus_wb_dat_i
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        REQ,
        RDOUT,
        FIN
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [8:0]            cnt_q, cnt_d;
    logic                  op_q, op_d;
    logic [TW-1:0]         tcnt_q, tcnt_d;
    logic [TW-1:0]         tcnt_inc;
    logic [31:0]           wdat_q, wdat_d;
    logic [31:0]           rdat_q, rdat_d;
    logic                  err_q, err_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  wr_ready_q, wr_ready_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  stb_q, stb_d;
    logic                  we_q, we_d;
    logic [3:0]            sel_q, sel_d;
    logic                  unused_addr_lsb;

    assign unused_addr_lsb = ^cmd_addr[1:0];
    assign tcnt_inc        = tcnt_q + TW'(1);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        tcnt_d  = tcnt_q;
        wdat_d  = wdat_q;
        rdat_d  = rdat_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d  = {cmd_addr[ADDR_WIDTH-1:2], 2'b00};
                    cnt_d   = (cmd_len == 8'd0) ? 9'd256 : {1'b0, cmd_len};
                    op_d    = cmd_write;
                    err_d   = 1'b0;
                    tcnt_d  = '0;
                    state_d = cmd_write ? FETCH : REQ;
                end
            end
            FETCH: begin
                if (wr_valid) begin
                    wdat_d  = wr_data;
                    tcnt_d  = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                // An ack arriving on the expiry cycle still completes the word.
                if (rambus_wb_ack_i) begin
                    if (op_q) begin
                        cnt_d   = cnt_q - 9'd1;
                        addr_d  = addr_q + ADDR_WIDTH'(4);
                        state_d = (cnt_q == 9'd1) ? FIN : FETCH;
                    end else begin
                        rdat_d  = rambus_wb_dat_i;
                        state_d = RDOUT;
                    end
                end else if (tcnt_inc == TW'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    state_d = FIN;
                end else begin
                    tcnt_d = tcnt_inc;
                end
            end
            RDOUT: begin
                if (rd_ready) begin
                    cnt_d   = cnt_q - 9'd1;
                    addr_d  = addr_q + ADDR_WIDTH'(4);
                    tcnt_d  = '0;
                    state_d = (cnt_q == 9'd1) ? FIN : REQ;
                end
            end
            FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register with it.
    always_comb begin
        cmd_ready_d = (state_d == IDLE);
        wr_ready_d  = (state_d == FETCH);
        stb_d       = (state_d == REQ);
        we_d        = stb_d & op_d;
        sel_d       = stb_d ? 4'hF : 4'h0;
        rd_valid_d  = (state_d == RDOUT);
        busy_d      = (state_d == FETCH) ||
                      (state_d == REQ) ||
                      (state_d == RDOUT);
        done_d      = (state_d == FIN);
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            op_q        <= 1'b0;
            tcnt_q      <= '0;
            wdat_q      <= '0;
            rdat_q      <= '0;
            err_q       <= 1'b0;
            cmd_ready_q <= 1'b1;
            wr_ready_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= 4'h0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            tcnt_q      <= tcnt_d;
            wdat_q      <= wdat_d;
            rdat_q      <= rdat_d;
            err_q       <= err_d;
            cmd_ready_q <= cmd_ready_d;
            wr_ready_q  <= wr_ready_d;
            rd_valid_q  <= rd_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
        end
    end

`ifdef RAMBUS_MOVER_STATS_EN
    logic [STAT_WIDTH-1:0] stat_q, stat_d;

    always_comb begin
        stat_d = stat_q;
        if (state_q == IDLE && cmd_valid) begin
            stat_d = '0;
        end else if (state_q == REQ && stb_q &&
                     !rambus_wb_ack_i && !(&stat_q)) begin
            stat_d = stat_q + STAT_WIDTH'(1);
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            stat_q <= '0;
        end else begin
            stat_q <= stat_d;
        end
    end

    assign stat_wait = stat_q;
`else
    assign stat_wait = '0;
`endif

    assign cmd_ready       = cmd_ready_q;
    assign wr_ready        = wr_ready_q;
    assign rd_valid        = rd_valid_q;
    assign rd_data         = rdat_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign err             = err_q;
    assign rambus_wb_clk_o = wb_clk_i;
    assign rambus_wb_rst_o = ~wb_rst_n_i;
    assign rambus_wb_stb_o = stb_q;
    assign rambus_wb_cyc_o = stb_q;
    assign rambus_wb_we_o  = we_q;
    assign rambus_wb_sel_o = sel_q;
    assign rambus_wb_dat_o = wdat_q;
    assign rambus_wb_adr_o = addr_q;

endmodule

// File: tb/tb_rambus_block_mover.sv
// Directed bench for rambus_block_mover with a wishbone memory responder.
// Stat expectations follow RAMBUS_MOVER_STATS_EN when defined.
module tb_rambus_block_mover;

    localparam int BUDGET = 2000;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [9:0]  cmd_addr;
    logic [7:0]  cmd_len;
    logic [31:0] wr_data;
    logic        wr_valid, wr_ready;
    logic [31:0] rd_data;
    logic        rd_valid, rd_ready;
    logic        busy, done, err;
    logic [15:0] stat_wait;
    logic        wb_clk, wb_rst, stb, cyc, we;
    logic [3:0]  sel;
    logic [31:0] dat_o, dat_i;
    logic [9:0]  adr;
    logic        ack;

    rambus_block_mover #(
        .ADDR_WIDTH(10),
        .TIMEOUT(8),
        .STAT_WIDTH(16)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_n_i(rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr(cmd_addr),
        .cmd_len(cmd_len),
        .wr_data(wr_data),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .rd_data(rd_data),
        .rd_valid(rd_valid),
        .rd_ready(rd_ready),
        .busy(busy),
        .done(done),
        .err(err),
        .stat_wait(stat_wait),
        .rambus_wb_clk_o(wb_clk),
        .rambus_wb_rst_o(wb_rst),
        .rambus_wb_stb_o(stb),
        .rambus_wb_cyc_o(cyc),
        .rambus_wb_we_o(we),
        .rambus_wb_sel_o(sel),
        .rambus_wb_dat_o(dat_o),
        .rambus_wb_adr_o(adr),
        .rambus_wb_ack_i(ack),
        .rambus_wb_dat_i(dat_i)
    );

    typedef struct packed {
        logic             wr;
        logic [9:0]       addr;
        logic [7:0]       len;
        logic [7:0]       delay;
        logic [3:0]       sw;
        logic [3:0][31:0] dat;
        logic [3:0][9:0]  adr;
        logic             err;
        logic [15:0]      stat;
    } vec_t;

    int          n_vec = 0;
    int          n_fail = 0;
    int          rsp_delay = 0;
    int          done_cnt = 0;
    int          stb_cnt = 0;
    logic [31:0] mem [256];
    logic [9:0]  lq_adr [$];
    logic        lq_we [$];
    logic [3:0]  lq_sel [$];
    logic [31:0] lq_dat [$];
    vec_t        vecs [7];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_stat(input logic [15:0] s);
`ifdef RAMBUS_MOVER_STATS_EN
        return s;
`else
        return 16'd0 & s;
`endif
    endfunction

    initial begin
        int wcnt;
        logic [7:0] idx;
        ack = 1'b0;
        dat_i = '0;
        wcnt = 0;
        for (int k = 0; k < 256; k++) mem[k] = 32'hBAD0_0000 + k;
        forever begin
            @(negedge clk);
            if (ack) begin
                ack = 1'b0;
                wcnt = 0;
            end else if (rst_n && cyc && stb) begin
                if (wcnt == rsp_delay) begin
                    ack = 1'b1;
                    idx = adr[9:2];
                    lq_adr.push_back(adr);
                    lq_we.push_back(we);
                    lq_sel.push_back(sel);
                    lq_dat.push_back(dat_o);
                    if (we) mem[idx] = dat_o;
                    else dat_i = mem[idx];
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
            if (stb) stb_cnt++;
        end
    end

    task automatic run_cmd(input vec_t v, input string nm);
        int n, i, st, d0, len, m;
        logic take;
        logic [31:0] held;
        len = (v.len == 8'd0) ? 256 : int'(v.len);
        rsp_delay = int'(v.delay);
        lq_adr.delete();
        lq_we.delete();
        lq_sel.delete();
        lq_dat.delete();
        d0 = done_cnt;
        held = '0;
        chk({nm, ".cmd_ready_idle"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_write = v.wr;
        cmd_addr = v.addr;
        cmd_len = v.len;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk({nm, ".busy"}, 32'(busy), 32'd1);
        chk({nm, ".cmd_ready_busy"}, 32'(cmd_ready), 32'd0);
        chk({nm, ".err_cleared"}, 32'(err), 32'd0);
        i = 0;
        n = 0;
        if (v.wr) begin
            wr_valid = 1'b1;
            wr_data = v.dat[0];
            while (i < len && n < BUDGET) begin
                take = wr_ready;
                @(negedge clk);
                n++;
                if (take) begin
                    i++;
                    if (i < len) wr_data = v.dat[i];
                    else wr_valid = 1'b0;
                end
            end
            wr_valid = 1'b0;
        end else begin
            st = 0;
            while (i < len && n < BUDGET) begin
                if (rd_valid && i == int'(v.sw) && st < 5) begin
                    rd_ready = 1'b0;
                    if (st == 0) begin
                        held = rd_data;
                    end else begin
                        chk({nm, ".rd_hold"}, rd_data, held);
                        chk({nm, ".no_stb_stall"}, 32'(stb), 32'd0);
                    end
                    st++;
                end else begin
                    rd_ready = 1'b1;
                end
                if (rd_valid && rd_ready) begin
                    chk($sformatf("%s.rd_data%0d", nm, i), rd_data, v.dat[i]);
                    i++;
                end
                @(negedge clk);
                n++;
            end
            rd_ready = 1'b1;
        end
        chk({nm, ".stream_words"}, 32'(i), 32'(len));
        n = 0;
        while (!done && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        chk({nm, ".done"}, 32'(done), 32'd1);
        chk({nm, ".err"}, 32'(err), 32'(v.err));
        chk({nm, ".busy_fin"}, 32'(busy), 32'd0);
        chk({nm, ".stat"}, 32'(stat_wait), 32'(exp_stat(v.stat)));
        @(negedge clk);
        chk({nm, ".cmd_ready_after"}, 32'(cmd_ready), 32'd1);
        chk({nm, ".done_once"}, 32'(done_cnt - d0), 32'd1);
        chk({nm, ".wb_count"}, 32'(lq_adr.size()), 32'(len));
        m = (lq_adr.size() < len) ? lq_adr.size() : len;
        for (int k = 0; k < m; k++) begin
            chk($sformatf("%s.adr%0d", nm, k), 32'(lq_adr[k]), 32'(v.adr[k]));
            chk($sformatf("%s.we%0d", nm, k), 32'(lq_we[k]), 32'(v.wr));
            chk($sformatf("%s.sel%0d", nm, k), 32'(lq_sel[k]), 32'hF);
            if (v.wr)
                chk($sformatf("%s.wdat%0d", nm, k), lq_dat[k], v.dat[k]);
        end
    endtask

    initial begin
        int n, d0;
        vec_t t;
        vecs[0] = '{wr: 1'b1, addr: 10'h010, len: 8'd3, delay: 8'd1,
                    sw: 4'hF, dat: {32'h0, 32'hC3, 32'hB2, 32'hA1},
                    adr: {10'h0, 10'h018, 10'h014, 10'h010},
                    err: 1'b0, stat: 16'd3};
        vecs[1] = '{wr: 1'b0, addr: 10'h010, len: 8'd3, delay: 8'd1,
                    sw: 4'h1, dat: {32'h0, 32'hC3, 32'hB2, 32'hA1},
                    adr: {10'h0, 10'h018, 10'h014, 10'h010},
                    err: 1'b0, stat: 16'd3};
        vecs[2] = '{wr: 1'b1, addr: 10'h3F8, len: 8'd4, delay: 8'd0,
                    sw: 4'hF, dat: {32'h44, 32'h33, 32'h22, 32'h11},
                    adr: {10'h004, 10'h000, 10'h3FC, 10'h3F8},
                    err: 1'b0, stat: 16'd0};
        vecs[3] = '{wr: 1'b0, addr: 10'h3F8, len: 8'd4, delay: 8'd2,
                    sw: 4'hF, dat: {32'h44, 32'h33, 32'h22, 32'h11},
                    adr: {10'h004, 10'h000, 10'h3FC, 10'h3F8},
                    err: 1'b0, stat: 16'd8};
        vecs[4] = '{wr: 1'b1, addr: 10'h023, len: 8'd1, delay: 8'd0,
                    sw: 4'hF, dat: {32'h0, 32'h0, 32'h0, 32'h55},
                    adr: {10'h0, 10'h0, 10'h0, 10'h020},
                    err: 1'b0, stat: 16'd0};
        vecs[5] = '{wr: 1'b0, addr: 10'h021, len: 8'd1, delay: 8'd7,
                    sw: 4'hF, dat: {32'h0, 32'h0, 32'h0, 32'h55},
                    adr: {10'h0, 10'h0, 10'h0, 10'h020},
                    err: 1'b0, stat: 16'd7};
        vecs[6] = '{wr: 1'b0, addr: 10'h010, len: 8'd2, delay: 8'd3,
                    sw: 4'hF, dat: {32'h0, 32'h0, 32'hB2, 32'hA1},
                    adr: {10'h0, 10'h0, 10'h014, 10'h010},
                    err: 1'b0, stat: 16'd6};

        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr = '0;
        cmd_len = '0;
        wr_data = '0;
        wr_valid = 1'b0;
        rd_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst.cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst.wb_rst", 32'(wb_rst), 32'd1);
        chk("rst.stb", 32'(stb), 32'd0);
        chk("rst.cyc", 32'(cyc), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.err", 32'(err), 32'd0);
        chk("rst.wr_ready", 32'(wr_ready), 32'd0);
        chk("rst.rd_valid", 32'(rd_valid), 32'd0);
        chk("rst.adr", 32'(adr), 32'd0);
        chk("rst.stat", 32'(stat_wait), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("run.wb_rst", 32'(wb_rst), 32'd0);

        for (int v = 0; v < 7; v++) run_cmd(vecs[v], $sformatf("vec%0d", v));

        rsp_delay = 1000;
        stb_cnt = 0;
        d0 = done_cnt;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr = 10'h040;
        cmd_len = 8'd2;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (!done && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        chk("tmo.done", 32'(done), 32'd1);
        chk("tmo.err", 32'(err), 32'd1);
        chk("tmo.stb_cycles", 32'(stb_cnt), 32'd8);
        chk("tmo.stb_low", 32'(stb), 32'd0);
        chk("tmo.rd_valid", 32'(rd_valid), 32'd0);
        chk("tmo.stat", 32'(stat_wait), 32'(exp_stat(16'd8)));
        @(negedge clk);
        chk("tmo.cmd_ready", 32'(cmd_ready), 32'd1);
        chk("tmo.err_sticky", 32'(err), 32'd1);
        chk("tmo.done_once", 32'(done_cnt - d0), 32'd1);
        run_cmd(vecs[4], "tmo_clear");

        rsp_delay = 1000;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr = 10'h100;
        cmd_len = 8'd0;
        @(negedge clk);
        cmd_valid = 1'b0;
        wr_valid = 1'b1;
        wr_data = 32'hDEAD_BEEF;
        @(negedge clk);
        wr_valid = 1'b0;
        n = 0;
        while (!stb && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rstreq.stb_up", 32'(stb), 32'd1);
        chk("rstreq.we", 32'(we), 32'd1);
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        chk("rstreq.stb", 32'(stb), 32'd0);
        chk("rstreq.cyc", 32'(cyc), 32'd0);
        chk("rstreq.busy", 32'(busy), 32'd0);
        chk("rstreq.cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rstreq.wb_rst", 32'(wb_rst), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rstreq.no_done", 32'(done_cnt - d0), 32'd0);
        chk("rstreq.idle_stb", 32'(stb), 32'd0);
        t = '{wr: 1'b1, addr: 10'h104, len: 8'd1, delay: 8'd0,
              sw: 4'hF, dat: {32'h0, 32'h0, 32'h0, 32'h77},
              adr: {10'h0, 10'h0, 10'h0, 10'h104},
              err: 1'b0, stat: 16'd0};
        run_cmd(t, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
